// File: rtl/ramb_asym_dp_sc.sv
// Single-clock true-dual-port RAM with independent, power-of-two related port widths,
// optional parity lanes, per-port write modes, optional output pipeline and collision tracking.
module ramb_asym_dp_sc #(
  parameter int unsigned MEM_BITS     = 16384,
  parameter int unsigned DW_A         = 4,
  parameter int unsigned DW_B         = 16,
  parameter int unsigned PW_A         = 0,
  parameter int unsigned PW_B         = 2,
  parameter string       WRITE_MODE_A = "WRITE_FIRST",
  parameter string       WRITE_MODE_B = "WRITE_FIRST",
  parameter int unsigned DO_REG_A     = 0,
  parameter int unsigned DO_REG_B     = 0,
  localparam int unsigned PWA_E       = (PW_A > 0) ? PW_A : 1,
  localparam int unsigned PWB_E       = (PW_B > 0) ? PW_B : 1,
  localparam int unsigned AW_A        = $clog2(MEM_BITS / DW_A),
  localparam int unsigned AW_B        = $clog2(MEM_BITS / DW_B),
  parameter logic [PWA_E+DW_A-1:0] INIT_A  = '0,
  parameter logic [PWA_E+DW_A-1:0] SRVAL_A = '0,
  parameter logic [PWB_E+DW_B-1:0] INIT_B  = '0,
  parameter logic [PWB_E+DW_B-1:0] SRVAL_B = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENA,
  input  logic             WEA,
  input  logic             SSRA,
  input  logic [AW_A-1:0]  ADDRA,
  input  logic [DW_A-1:0]  DIA,
  input  logic [PWA_E-1:0] DIPA,
  output logic [DW_A-1:0]  DOA,
  output logic [PWA_E-1:0] DOPA,
  input  logic             ENB,
  input  logic             WEB,
  input  logic             SSRB,
  input  logic [AW_B-1:0]  ADDRB,
  input  logic [DW_B-1:0]  DIB,
  input  logic [PWB_E-1:0] DIPB,
  output logic [DW_B-1:0]  DOB,
  output logic [PWB_E-1:0] DOPB,
  output logic             COLL,
  output logic [15:0]      COLL_CNT
);

  localparam int unsigned R     = DW_B / DW_A;
  localparam int unsigned RL    = $clog2(R);
  localparam int unsigned LW    = (RL > 0) ? RL : 1;
  localparam int unsigned DEPTH = MEM_BITS / DW_B;
  localparam int unsigned AWID  = PWA_E + DW_A;
  localparam int unsigned BWID  = PWB_E + DW_B;
  localparam bit WF_A = (WRITE_MODE_A == "WRITE_FIRST");
  localparam bit RF_A = (WRITE_MODE_A == "READ_FIRST");
  localparam bit WF_B = (WRITE_MODE_B == "WRITE_FIRST");
  localparam bit RF_B = (WRITE_MODE_B == "READ_FIRST");

  logic [DW_B-1:0]  mem_d [DEPTH];
  logic [PWB_E-1:0] mem_p [DEPTH];

  logic [AW_B-1:0]  a_word;
  logic [LW-1:0]    a_lane;
  logic [DW_A-1:0]  rd_da;
  logic [PWA_E-1:0] rd_pa;
  logic [PWA_E-1:0] dipa_w;
  logic [BWID-1:0]  rd_b;
  logic [AWID-1:0]  la_q, la_d, pa_q, pa_d, do_a;
  logic [BWID-1:0]  lb_q, lb_d, pb_q, pb_d, do_b;
  logic             coll_c;
  logic             coll_q, coll_d;
  logic [15:0]      cnt_q, cnt_d;

  // Port A address split into the wide word and the narrow lane within it
  assign a_word = AW_B'(ADDRA >> RL);
  assign a_lane = (R > 1) ? LW'(ADDRA) : '0;
  assign dipa_w = (PW_A > 0) ? DIPA : '0;

  // Pre-edge read views; a reader colliding with a writer therefore sees old data
  always_comb begin
    rd_da = mem_d[a_word][a_lane*DW_A +: DW_A];
    rd_pa = '0;
    if (PW_A > 0) rd_pa = mem_p[a_word][a_lane*PWA_E +: PWA_E];
    rd_b  = {mem_p[ADDRB], mem_d[ADDRB]};
  end

  // Storage writes; port B is applied last so it wins overlapping bits
  always_ff @(posedge CLK) begin
    if (ENA && WEA) begin
      mem_d[a_word][a_lane*DW_A +: DW_A] <= DIA;
      if (PW_A > 0) mem_p[a_word][a_lane*PWA_E +: PWA_E] <= DIPA;
    end
    if (ENB && WEB) begin
      mem_d[ADDRB] <= DIB;
      mem_p[ADDRB] <= DIPB;
    end
  end

  // Port A output latch and pipeline next-state
  always_comb begin
    la_d = la_q;
    pa_d = pa_q;
    if (ENA) begin
      if (SSRA && (DO_REG_A == 0)) la_d = SRVAL_A;
      else if (!WEA || RF_A)       la_d = {rd_pa, rd_da};
      else if (WF_A)               la_d = {dipa_w, DIA};
      pa_d = SSRA ? SRVAL_A : la_q;
    end
  end

  // Port B output latch and pipeline next-state
  always_comb begin
    lb_d = lb_q;
    pb_d = pb_q;
    if (ENB) begin
      if (SSRB && (DO_REG_B == 0)) lb_d = SRVAL_B;
      else if (!WEB || RF_B)       lb_d = rd_b;
      else if (WF_B)               lb_d = {DIPB, DIB};
      pb_d = SSRB ? SRVAL_B : lb_q;
    end
  end

  // Collision detect and saturating count
  assign coll_c = ENA && ENB && (a_word == ADDRB) && (WEA || WEB);
  always_comb begin
    coll_d = coll_c;
    cnt_d  = cnt_q;
    if (coll_c && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Output and collision state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      la_q   <= INIT_A;
      pa_q   <= INIT_A;
      lb_q   <= INIT_B;
      pb_q   <= INIT_B;
      coll_q <= 1'b0;
      cnt_q  <= 16'd0;
    end else begin
      la_q   <= la_d;
      pa_q   <= pa_d;
      lb_q   <= lb_d;
      pb_q   <= pb_d;
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  // Final output stage selection
  assign do_a     = (DO_REG_A != 0) ? pa_q : la_q;
  assign do_b     = (DO_REG_B != 0) ? pb_q : lb_q;
  assign DOA      = do_a[DW_A-1:0];
  assign DOPA     = (PW_A > 0) ? do_a[AWID-1:DW_A] : '0;
  assign DOB      = do_b[DW_B-1:0];
  assign DOPB     = do_b[BWID-1:DW_B];
  assign COLL     = coll_q;
  assign COLL_CNT = cnt_q;

endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// Scoreboard bench: four RAM variants share one stimulus stream (B port WRITE_FIRST,
// READ_FIRST, NO_CHANGE, and WRITE_FIRST with output register plus SRVAL).
module tb_ramb_asym_dp_sc;

  typedef struct {
    string       tag;
    logic [3:0]  doa;
    logic [15:0] b_wf, b_rf, b_nc, b_pp;
    logic [1:0]  p_wf, p_rf, p_nc, p_pp;
    logic        coll;
    logic [15:0] cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic ENA = 0, WEA = 0, SSRA = 0, ENB = 0, WEB = 0, SSRB = 0;
  logic [11:0] ADDRA = '0;
  logic [9:0]  ADDRB = '0;
  logic [3:0]  DIA = '0;
  logic [0:0]  DIPA = '0;
  logic [15:0] DIB = '0;
  logic [1:0]  DIPB = '0;

  logic [3:0]  doa  [4];
  logic [0:0]  dopa [4];
  logic [15:0] dob  [4];
  logic [1:0]  dopb [4];
  logic        coll [4];
  logic [15:0] cnt  [4];

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 CLK = ~CLK;

  ramb_asym_dp_sc u_wf (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DIPA(DIPA), .DOA(doa[0]), .DOPA(dopa[0]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .DOB(dob[0]), .DOPB(dopb[0]),
    .COLL(coll[0]), .COLL_CNT(cnt[0]));

  ramb_asym_dp_sc #(.WRITE_MODE_B("READ_FIRST")) u_rf (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DIPA(DIPA), .DOA(doa[1]), .DOPA(dopa[1]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .DOB(dob[1]), .DOPB(dopb[1]),
    .COLL(coll[1]), .COLL_CNT(cnt[1]));

  ramb_asym_dp_sc #(.WRITE_MODE_B("NO_CHANGE")) u_nc (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DIPA(DIPA), .DOA(doa[2]), .DOPA(dopa[2]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .DOB(dob[2]), .DOPB(dopb[2]),
    .COLL(coll[2]), .COLL_CNT(cnt[2]));

  ramb_asym_dp_sc #(.DO_REG_B(1), .SRVAL_B(18'h3_5A5A)) u_pp (
    .CLK(CLK), .RST_N(RST_N), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DIPA(DIPA), .DOA(doa[3]), .DOPA(dopa[3]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
    .ADDRB(ADDRB), .DIB(DIB), .DIPB(DIPB), .DOB(dob[3]), .DOPB(dopb[3]),
    .COLL(coll[3]), .COLL_CNT(cnt[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string t, input logic [3:0] a,
                              input logic [15:0] wf, input logic [1:0] pwf,
                              input logic [15:0] rf, input logic [1:0] prf,
                              input logic [15:0] nc, input logic [1:0] pnc,
                              input logic [15:0] pp, input logic [1:0] ppp,
                              input logic c, input logic [15:0] n);
    exp_t e;
    e.tag = t; e.doa = a;
    e.b_wf = wf; e.p_wf = pwf; e.b_rf = rf; e.p_rf = prf;
    e.b_nc = nc; e.p_nc = pnc; e.b_pp = pp; e.p_pp = ppp;
    e.coll = c; e.cnt = n;
    return e;
  endfunction

  // Drive one edge worth of inputs and queue the outputs expected after that edge
  task automatic cyc(input logic ea, input logic wa, input logic [11:0] aa, input logic [3:0] da,
                     input logic eb, input logic wb, input logic sb, input logic [9:0] ab,
                     input logic [15:0] db, input logic [1:0] pb, input exp_t e);
    ENA = ea; WEA = wa; ADDRA = aa; DIA = da;
    ENB = eb; WEB = wb; SSRB = sb; ADDRB = ab; DIB = db; DIPB = pb;
    q.push_back(e);
    @(posedge CLK);
    #4;
  endtask

  // Monitor: compare every output shortly after each active edge against the queued record
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, " DOA"},      32'(doa[0]),  32'(e.doa));
        chk({e.tag, " DOPA"},     32'(dopa[0]), 32'(0));
        chk({e.tag, " DOB wf"},   32'(dob[0]),  32'(e.b_wf));
        chk({e.tag, " DOPB wf"},  32'(dopb[0]), 32'(e.p_wf));
        chk({e.tag, " DOB rf"},   32'(dob[1]),  32'(e.b_rf));
        chk({e.tag, " DOPB rf"},  32'(dopb[1]), 32'(e.p_rf));
        chk({e.tag, " DOB nc"},   32'(dob[2]),  32'(e.b_nc));
        chk({e.tag, " DOPB nc"},  32'(dopb[2]), 32'(e.p_nc));
        chk({e.tag, " DOB pp"},   32'(dob[3]),  32'(e.b_pp));
        chk({e.tag, " DOPB pp"},  32'(dopb[3]), 32'(e.p_pp));
        chk({e.tag, " COLL"},     32'(coll[0]), 32'(e.coll));
        chk({e.tag, " COLL_CNT"}, 32'(cnt[0]),  32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RST_N = 1'b0;
    #2;
    chk("reset DOA", 32'(doa[0]), 32'(0));
    chk("reset DOB", 32'(dob[0]), 32'(0));
    chk("reset COLL_CNT", 32'(cnt[0]), 32'(0));
    #9 RST_N = 1'b1;

    //   ea wa addrA  dA  eb wb sb addrB  dB       pB
    cyc(0, 0, 12'h000, 4'h0, 1, 1, 0, 10'h005, 16'hABCD, 2'b10,
        mk("c01 Bwr5", 4'h0, 16'hABCD, 2'd2, 16'h0000, 2'd0, 16'h0000, 2'd0, 16'h0000, 2'd0, 0, 16'd0));
    cyc(1, 0, 12'h014, 4'h0, 0, 0, 0, 10'h000, 16'h0000, 2'b00,
        mk("c02 Ard14", 4'hD, 16'hABCD, 2'd2, 16'h0000, 2'd0, 16'h0000, 2'd0, 16'h0000, 2'd0, 0, 16'd0));
    cyc(1, 0, 12'h015, 4'h0, 1, 0, 0, 10'h005, 16'h0000, 2'b00,
        mk("c03 Ard15 Brd5", 4'hC, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 0, 16'd0));
    cyc(1, 0, 12'h016, 4'h0, 0, 0, 0, 10'h000, 16'h0000, 2'b00,
        mk("c04 Ard16", 4'hB, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 0, 16'd0));
    cyc(1, 0, 12'h017, 4'h0, 0, 0, 0, 10'h000, 16'h0000, 2'b00,
        mk("c05 Ard17", 4'hA, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 0, 16'd0));
    cyc(0, 0, 12'h000, 4'h0, 1, 1, 0, 10'h003, 16'h1111, 2'b00,
        mk("c06 Bwr3 1111", 4'hA, 16'h1111, 2'd0, 16'h0000, 2'd0, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 0, 16'd0));
    cyc(0, 0, 12'h000, 4'h0, 1, 1, 0, 10'h003, 16'h2222, 2'b01,
        mk("c07 Bwr3 2222", 4'hA, 16'h2222, 2'd1, 16'h1111, 2'd0, 16'hABCD, 2'd2, 16'h1111, 2'd0, 0, 16'd0));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c08 Brd3", 4'hA, 16'h2222, 2'd1, 16'h2222, 2'd1, 16'h2222, 2'd1, 16'h2222, 2'd1, 0, 16'd0));
    cyc(1, 1, 12'h00C, 4'h7, 1, 1, 0, 10'h003, 16'hFFFF, 2'b11,
        mk("c09 WW coll", 4'h7, 16'hFFFF, 2'd3, 16'h2222, 2'd1, 16'h2222, 2'd1, 16'h2222, 2'd1, 1, 16'd1));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c10 Brd3 Bwins", 4'h7, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 0, 16'd1));
    cyc(1, 0, 12'h00C, 4'h0, 1, 1, 0, 10'h003, 16'h0000, 2'b00,
        mk("c11 RW coll", 4'hF, 16'h0000, 2'd0, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 1, 16'd2));
    cyc(1, 0, 12'h00C, 4'h0, 0, 0, 0, 10'h000, 16'h0000, 2'b00,
        mk("c12 Ard after", 4'h0, 16'h0000, 2'd0, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 16'hFFFF, 2'd3, 0, 16'd2));
    cyc(1, 1, 12'h00D, 4'h9, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c13 WR coll", 4'h9, 16'h0000, 2'd0, 16'h0000, 2'd0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 16'd3));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c14 Brd3 lane1", 4'h9, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'h0000, 2'd0, 0, 16'd3));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 0, 10'h005, 16'h0000, 2'b00,
        mk("c15 pipe issue", 4'h9, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'h0090, 2'd0, 0, 16'd3));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c16 pipe out", 4'h9, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'hABCD, 2'd2, 0, 16'd3));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 1, 10'h005, 16'h0000, 2'b00,
        mk("c17 SSRB", 4'h9, 16'h0000, 2'd0, 16'h0000, 2'd0, 16'h0000, 2'd0, 16'h5A5A, 2'd3, 0, 16'd3));
    cyc(0, 0, 12'h000, 4'h0, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c18 latch kept", 4'h9, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'hABCD, 2'd2, 0, 16'd3));
    cyc(1, 0, 12'h00D, 4'h0, 1, 0, 0, 10'h005, 16'h0000, 2'b00,
        mk("c19 RR no coll", 4'h9, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'hABCD, 2'd2, 16'h0090, 2'd0, 0, 16'd3));

    // Asynchronous reset between edges
    #1 RST_N = 1'b0;
    #1;
    chk("midrst DOA", 32'(doa[0]), 32'(0));
    chk("midrst DOB wf", 32'(dob[0]), 32'(0));
    chk("midrst DOPB wf", 32'(dopb[0]), 32'(0));
    chk("midrst DOB pp", 32'(dob[3]), 32'(0));
    chk("midrst COLL_CNT", 32'(cnt[0]), 32'(0));
    #1 RST_N = 1'b1;

    cyc(1, 0, 12'h014, 4'h0, 1, 0, 0, 10'h003, 16'h0000, 2'b00,
        mk("c20 after rst", 4'hD, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'h0090, 2'd0, 16'h0000, 2'd0, 0, 16'd0));

    // 65536 back-to-back read/write collisions, then one more to probe saturation
    ENA = 1; WEA = 0; ADDRA = 12'h01C; ENB = 1; WEB = 1; SSRB = 0; ADDRB = 10'h007;
    DIB = 16'h1234; DIPB = 2'b00;
    repeat (65536) @(posedge CLK);
    #4;
    cyc(1, 0, 12'h01C, 4'h0, 1, 1, 0, 10'h007, 16'h1234, 2'b00,
        mk("c21 saturate", 4'h4, 16'h1234, 2'd0, 16'h1234, 2'd0, 16'h0090, 2'd0, 16'h1234, 2'd0, 1, 16'hFFFF));
    cyc(0, 0, 12'h000, 4'h0, 0, 0, 0, 10'h000, 16'h0000, 2'b00,
        mk("c22 idle", 4'h4, 16'h1234, 2'd0, 16'h1234, 2'd0, 16'h0090, 2'd0, 16'h1234, 2'd0, 0, 16'hFFFF));

    repeat (2) @(posedge CLK);
    #4;
    chk("scoreboard drained", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
